inst_fetch_unit: RTL

- Instruction-fetch stage of the teaching CPU.
- Owns the program counter and drives the 6-bit word address into the combinational instruction ROM.
- Captures the returned 32-bit instruction, with its PC, into the IF/ID pipeline register that feeds the decoder.
- Handles decode-stage stalls and branch/jump redirects, including flushing the wrong-path instruction.

---
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and loads the IF/ID pipeline register. It honours decode
// stalls and branch/jump redirects. A redirect flushes the wrong-path slot.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_in,
  output logic [DATA_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid
);

  // The fetch behaviour is fully set by the inputs on each edge. No mode is
  // stored between cycles, so the only state is the PC and the IF/ID slot.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,  // advance: capture the ROM word and step the PC
    MODE_HOLD  = 2'd1,  // stall: freeze the PC and the IF/ID slot
    MODE_FLUSH = 2'd2   // redirect: load the target and insert a bubble
  } fetch_mode_e;

  fetch_mode_e       mode;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc_plus1;

  logic [ADDR_W-1:0] pc_q,             pc_d;
  logic [DATA_W-1:0] if_id_inst_q,     if_id_inst_d;
  logic [ADDR_W-1:0] if_id_pc_q,       if_id_pc_d;
  logic [ADDR_W-1:0] if_id_pc_plus1_q, if_id_pc_plus1_d;
  logic              if_id_valid_q,    if_id_valid_d;

  // pc+1 wraps naturally at ADDR_W bits. 6'h3F steps to 6'h00.
  assign pc_plus1 = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Select the redirect target and the fetch mode. A jump beats a branch,
  // and any redirect beats a stall.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
    mode            = MODE_RUN;
    if (redirect) begin
      mode = MODE_FLUSH;
    end else if (stall) begin
      mode = MODE_HOLD;
    end
  end

  // Compute the next PC and IF/ID contents for the selected mode.
  always_comb begin
    pc_d             = pc_q;
    if_id_inst_d     = if_id_inst_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus1_d = if_id_pc_plus1_q;
    if_id_valid_d    = if_id_valid_q;
    unique case (mode)
      MODE_FLUSH: begin
        // Drop the word fetched from the old PC. Zeroed fields keep the
        // bubble free of stale data.
        pc_d             = redirect_target;
        if_id_inst_d     = '0;
        if_id_pc_d       = '0;
        if_id_pc_plus1_d = '0;
        if_id_valid_d    = 1'b0;
      end
      MODE_HOLD: begin
        // All registers keep the values from the defaults above.
      end
      default: begin
        pc_d             = pc_plus1;
        if_id_inst_d     = inst_in;
        if_id_pc_d       = pc_q;
        if_id_pc_plus1_d = pc_plus1;
        if_id_valid_d    = 1'b1;
      end
    endcase
  end

  // Register the PC and the IF/ID slot. Reset wins over stall and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      if_id_inst_q     <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus1_q <= '0;
      if_id_valid_q    <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_inst_q     <= if_id_inst_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus1_q <= if_id_pc_plus1_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign inst_addr      = pc_q;
  assign if_id_inst     = if_id_inst_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus1 = if_id_pc_plus1_q;
  assign if_id_valid    = if_id_valid_q;

endmodule
